// File: rtl/pipe_credit_sink.sv
// Receiving end of a fixed-latency valid-only pipeline: credit-gated issue, result FIFO
// and a ready/valid output port, with a sticky overflow trap for protocol violations.
module pipe_credit_sink #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       pipe_valid,
  input  logic [WIDTH-1:0]           pipe_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic issue_fire, pop_fire, full, push_acc;

  assign issue_ready = (credits_q != '0);
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign credits     = credits_q;
  assign count       = count_q;
  assign overflow    = overflow_q;

  assign issue_fire = issue_valid & issue_ready;
  assign pop_fire   = out_valid & out_ready;
  assign full       = (count_q == CW'(DEPTH));
  // A full FIFO can still take a result when the head leaves in the same cycle.
  assign push_acc   = pipe_valid & (~full | pop_fire);

  always_comb begin
    credits_d = credits_q;
    if (issue_fire && !pop_fire) begin
      credits_d = credits_q - CW'(1);
    end else if (pop_fire && !issue_fire && credits_q != CW'(DEPTH)) begin
      credits_d = credits_q + CW'(1);
    end

    count_d = count_q;
    if (push_acc && !pop_fire) begin
      count_d = count_q + CW'(1);
    end else if (!push_acc && pop_fire) begin
      count_d = count_q - CW'(1);
    end

    overflow_d = overflow_q | (pipe_valid & full & ~pop_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q  <= CW'(DEPTH);
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_q[wr_ptr_q] <= pipe_data;
  end

endmodule
